pixel_port_arbiter: RTL and testbench

- Shares the single VGA pixel-write port and the canvas memory port between two requesters: the drawing datapath (cell paint/clear) and the RAM datapath (save/restore slot copy).
- Grants bounded bursts, is round-robin fair, and inserts a one-cycle turnaround on every ownership change.
- All outputs to the VGA adapter and memory are registered.
- Sits between both datapaths and the top-level VGA/memory connections. It replaces the static datapath-select mux.

---
 rtl/pixel_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_pixel_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_port_arbiter.sv
// Round-robin arbiter sharing the VGA pixel port and canvas memory port
// between the drawing and RAM datapaths, with bounded bursts and turnaround.
module pixel_port_arbiter #(
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 120,
    parameter int MAX_BURST     = 25,
    localparam int XW = $clog2(SCREEN_WIDTH) + 1,
    localparam int YW = $clog2(SCREEN_HEIGHT) + 1
) (
    input  logic          iClk,
    input  logic          iResetn,
    input  logic          iReq_draw,
    input  logic [XW-1:0] iX_draw,
    input  logic [YW-1:0] iY_draw,
    input  logic [2:0]    iColour_draw,
    input  logic [14:0]   iAddress_draw,
    input  logic          iWren_draw,
    input  logic          iReq_ram,
    input  logic [XW-1:0] iX_ram,
    input  logic [YW-1:0] iY_ram,
    input  logic [2:0]    iColour_ram,
    input  logic [14:0]   iAddress_ram,
    input  logic          iWren_ram,
    output logic          oGnt_draw,
    output logic          oGnt_ram,
    output logic [XW-1:0] oX_pixel,
    output logic [YW-1:0] oY_pixel,
    output logic [2:0]    oColour,
    output logic          oPlot,
    output logic [14:0]   oAddress,
    output logic          oWren,
    output logic [1:0]    oOwner
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_OWN_DRAW = 2'b01,
        S_OWN_RAM  = 2'b10,
        S_SWITCH   = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic          last_ram_q, last_ram_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          gnt_draw_q, gnt_draw_d;
    logic          gnt_ram_q, gnt_ram_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic [14:0]   addr_q, addr_d;
    logic          plot_q, plot_d;
    logic          wren_q, wren_d;
    logic [1:0]    owner_q, owner_d;
    logic          acc_draw, acc_ram;

    always_comb begin
        acc_draw   = gnt_draw_q & iReq_draw;
        acc_ram    = gnt_ram_q & iReq_ram;
        cnt_inc    = cnt_q;
        state_d    = state_q;
        last_ram_d = last_ram_q;
        cnt_d      = cnt_q;

        // Saturating beat count; the MAX_BURST-th beat itself triggers the hand-off
        if ((acc_draw | acc_ram) && (cnt_q != MAX_CNT))
            cnt_inc = cnt_q + CW'(1);

        unique case (state_q)
            S_IDLE: begin
                if (iReq_draw && iReq_ram)
                    state_d = last_ram_q ? S_OWN_DRAW : S_OWN_RAM;
                else if (iReq_draw)
                    state_d = S_OWN_DRAW;
                else if (iReq_ram)
                    state_d = S_OWN_RAM;
            end
            S_OWN_DRAW: begin
                cnt_d = cnt_inc;
                if (!iReq_draw || ((cnt_inc == MAX_CNT) && iReq_ram)) begin
                    state_d    = iReq_ram ? S_SWITCH : S_IDLE;
                    last_ram_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            S_OWN_RAM: begin
                cnt_d = cnt_inc;
                if (!iReq_ram || ((cnt_inc == MAX_CNT) && iReq_draw)) begin
                    state_d    = iReq_draw ? S_SWITCH : S_IDLE;
                    last_ram_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            S_SWITCH: begin
                state_d = last_ram_q ? S_OWN_DRAW : S_OWN_RAM;
            end
            default: state_d = S_IDLE;
        endcase

        gnt_draw_d = (state_d == S_OWN_DRAW);
        gnt_ram_d  = (state_d == S_OWN_RAM);
        // Owner is delayed one cycle so it lines up with the beat on the outputs
        owner_d    = state_q;

        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        addr_d   = addr_q;
        plot_d   = 1'b0;
        wren_d   = 1'b0;
        if (acc_draw) begin
            x_d      = iX_draw;
            y_d      = iY_draw;
            colour_d = iColour_draw;
            addr_d   = iAddress_draw;
            plot_d   = 1'b1;
            wren_d   = iWren_draw;
        end else if (acc_ram) begin
            x_d      = iX_ram;
            y_d      = iY_ram;
            colour_d = iColour_ram;
            addr_d   = iAddress_ram;
            plot_d   = 1'b1;
            wren_d   = iWren_ram;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iResetn) begin
            state_q    <= S_IDLE;
            last_ram_q <= 1'b1;
            cnt_q      <= '0;
            gnt_draw_q <= 1'b0;
            gnt_ram_q  <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            addr_q     <= '0;
            plot_q     <= 1'b0;
            wren_q     <= 1'b0;
            owner_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_ram_q <= last_ram_d;
            cnt_q      <= cnt_d;
            gnt_draw_q <= gnt_draw_d;
            gnt_ram_q  <= gnt_ram_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            addr_q     <= addr_d;
            plot_q     <= plot_d;
            wren_q     <= wren_d;
            owner_q    <= owner_d;
        end
    end

    assign oGnt_draw = gnt_draw_q;
    assign oGnt_ram  = gnt_ram_q;
    assign oX_pixel  = x_q;
    assign oY_pixel  = y_q;
    assign oColour   = colour_q;
    assign oPlot     = plot_q;
    assign oAddress  = addr_q;
    assign oWren     = wren_q;
    assign oOwner    = owner_q;

endmodule

// File: tb/tb_pixel_port_arbiter.sv
// Randomized bench for pixel_port_arbiter against a rule-level reference model,
// plus directed burst/turnaround checks and a MAX_BURST=1 instance.
module tb_pixel_port_arbiter;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int MB = 25;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          rq_d, rq_r;
    logic [XW-1:0] x_d, x_r;
    logic [YW-1:0] y_d, y_r;
    logic [2:0]    c_d, c_r;
    logic [14:0]   a_d, a_r;
    logic          w_d, w_r;

    logic          gnt_d, gnt_r, plot, ow;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic [2:0]    oc;
    logic [14:0]   oa;
    logic [1:0]    own;

    pixel_port_arbiter #(.SCREEN_WIDTH(160), .SCREEN_HEIGHT(120), .MAX_BURST(MB)) dut (
        .iClk(clk), .iResetn(rst_n),
        .iReq_draw(rq_d), .iX_draw(x_d), .iY_draw(y_d), .iColour_draw(c_d),
        .iAddress_draw(a_d), .iWren_draw(w_d),
        .iReq_ram(rq_r), .iX_ram(x_r), .iY_ram(y_r), .iColour_ram(c_r),
        .iAddress_ram(a_r), .iWren_ram(w_r),
        .oGnt_draw(gnt_d), .oGnt_ram(gnt_r), .oX_pixel(ox), .oY_pixel(oy),
        .oColour(oc), .oPlot(plot), .oAddress(oa), .oWren(ow), .oOwner(own)
    );

    logic          rst2_n, rq2;
    logic          gnt2_d, gnt2_r, plot2, ow2;
    logic [XW-1:0] ox2;
    logic [YW-1:0] oy2;
    logic [2:0]    oc2;
    logic [14:0]   oa2;
    logic [1:0]    own2;

    pixel_port_arbiter #(.SCREEN_WIDTH(160), .SCREEN_HEIGHT(120), .MAX_BURST(1)) dut2 (
        .iClk(clk), .iResetn(rst2_n),
        .iReq_draw(rq2), .iX_draw(9'd3), .iY_draw(8'd4), .iColour_draw(3'd1),
        .iAddress_draw(15'h0011), .iWren_draw(1'b1),
        .iReq_ram(rq2), .iX_ram(9'd5), .iY_ram(8'd6), .iColour_ram(3'd2),
        .iAddress_ram(15'h0022), .iWren_ram(1'b0),
        .oGnt_draw(gnt2_d), .oGnt_ram(gnt2_r), .oX_pixel(ox2), .oY_pixel(oy2),
        .oColour(oc2), .oPlot(plot2), .oAddress(oa2), .oWren(ow2), .oOwner(own2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: holder 0 none, 1 draw, 2 ram, 3 turnaround
    int          m_st = 0, m_last = 2, m_cnt = 0;
    bit          m_gd = 0, m_gr = 0;
    bit          acc_d = 0, acc_r = 0;
    logic [XW-1:0] e_x = '0;
    logic [YW-1:0] e_y = '0;
    logic [2:0]    e_c = '0;
    logic [14:0]   e_a = '0;
    bit          e_w = 0, e_plot = 0;
    int          e_own = 0;

    task automatic new_draw_beat();
        x_d = XW'($urandom_range(0, 159));
        y_d = YW'($urandom_range(0, 119));
        c_d = 3'($urandom);
        a_d = 15'($urandom);
        w_d = 1'($urandom);
    endtask

    task automatic new_ram_beat();
        x_r = XW'($urandom_range(0, 159));
        y_r = YW'($urandom_range(0, 119));
        c_r = 3'($urandom);
        a_r = 15'($urandom);
        w_r = 1'($urandom);
    endtask

    task automatic step();
        bit rd, rr, rs, own_req, oth_req;
        logic [XW-1:0] bx_d, bx_r;
        logic [YW-1:0] by_d, by_r;
        logic [2:0]    bc_d, bc_r;
        logic [14:0]   ba_d, ba_r;
        bit            bw_d, bw_r;
        rd = rq_d; rr = rq_r; rs = rst_n;
        bx_d = x_d; by_d = y_d; bc_d = c_d; ba_d = a_d; bw_d = w_d;
        bx_r = x_r; by_r = y_r; bc_r = c_r; ba_r = a_r; bw_r = w_r;
        @(posedge clk);
        if (!rs) begin
            m_st = 0; m_last = 2; m_cnt = 0; m_gd = 0; m_gr = 0;
            acc_d = 0; acc_r = 0;
            e_x = '0; e_y = '0; e_c = '0; e_a = '0; e_w = 0; e_plot = 0; e_own = 0;
        end else begin
            acc_d  = m_gd && rd;
            acc_r  = m_gr && rr;
            e_plot = acc_d || acc_r;
            e_w    = 0;
            if (acc_d) begin
                e_x = bx_d; e_y = by_d; e_c = bc_d; e_a = ba_d; e_w = bw_d;
            end else if (acc_r) begin
                e_x = bx_r; e_y = by_r; e_c = bc_r; e_a = ba_r; e_w = bw_r;
            end
            e_own = m_st;
            if (m_st == 0) begin
                if (rd && rr) m_st = (m_last == 2) ? 1 : 2;
                else if (rd) m_st = 1;
                else if (rr) m_st = 2;
            end else if (m_st == 3) begin
                m_st = 3 - m_last;
            end else begin
                own_req = (m_st == 1) ? rd : rr;
                oth_req = (m_st == 1) ? rr : rd;
                if (acc_d || acc_r) m_cnt = (m_cnt < MB) ? m_cnt + 1 : MB;
                if (!own_req || (m_cnt == MB && oth_req)) begin
                    m_last = m_st;
                    m_cnt  = 0;
                    m_st   = oth_req ? 3 : 0;
                end
            end
            m_gd = (m_st == 1);
            m_gr = (m_st == 2);
        end
        #1;
        check("gnt_draw", gnt_d, m_gd);
        check("gnt_ram", gnt_r, m_gr);
        check("gnt_excl", gnt_d & gnt_r, 0);
        check("plot", plot, e_plot);
        check("wren", ow, e_w);
        check("x", ox, e_x);
        check("y", oy, e_y);
        check("colour", oc, e_c);
        check("addr", oa, e_a);
        check("owner", own, e_own);
        if (acc_d) new_draw_beat();
        if (acc_r) new_ram_beat();
    endtask

    initial begin
        int n, seen, cnt_p, cnt_sw;
        rst_n = 1'b0; rq_d = 1'b0; rq_r = 1'b0;
        rst2_n = 1'b0; rq2 = 1'b0;
        new_draw_beat();
        new_ram_beat();
        step();
        step();
        rst_n = 1'b1;
        check("rst_plot", plot, 0);
        check("rst_owner", own, 0);

        // First beat latency
        x_d = 9'd10; y_d = 8'd20; c_d = 3'b101; a_d = 15'h0123; w_d = 1'b1;
        rq_d = 1'b1;
        step();
        check("A_gnt", gnt_d, 1);
        check("A_plot_early", plot, 0);
        step();
        rq_d = 1'b0;
        check("A_plot", plot, 1);
        check("A_x", ox, 10);
        check("A_y", oy, 20);
        check("A_colour", oc, 5);
        check("A_addr", oa, 15'h0123);
        check("A_wren", ow, 1);
        check("A_owner", own, 1);
        repeat (4) step();

        // Both requesting: draw bursts MAX_BURST, then ram
        rst_n = 1'b0; step(); rst_n = 1'b1;
        rq_d = 1'b1; rq_r = 1'b1;
        n = 0; seen = 0; cnt_sw = 0;
        for (int i = 0; i < 130; i++) begin
            step();
            if (gnt_r) seen = 1;
            if (gnt_d && !seen) n++;
            if (own == 2'b11) cnt_sw++;
        end
        check("B_first_burst", n, MB);
        check("B_switch_seen", cnt_sw > 0, 1);
        rq_d = 1'b0; rq_r = 1'b0;
        repeat (5) step();

        // Draw streams alone: no turnaround, 60 pulses
        rq_d = 1'b1;
        n = 0; cnt_p = 0; cnt_sw = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (acc_d) n++;
            rq_d = (n < 60);
            if (plot) cnt_p++;
            if (own == 2'b11) cnt_sw++;
        end
        check("C_pulses", cnt_p, 60);
        check("C_no_switch", cnt_sw, 0);

        // Draw owner drops after 7 beats while ram waits
        rq_d = 1'b1;
        step();
        rq_r = 1'b1;
        n = 0; cnt_p = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (acc_d) n++;
            rq_d = (n < 7);
            if (plot && own == 2'b01) cnt_p++;
            if (gnt_r) seen = 1;
        end
        check("D_draw_pulses", cnt_p, 7);
        check("D_ram_granted", seen, 1);
        repeat (5) step();

        // Reset mid ram burst, then draw wins the tie
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("E_owner", own, 0);
        check("E_plot", plot, 0);
        check("E_gnt_ram", gnt_r, 0);
        check("E_x", ox, 0);
        rq_d = 1'b1;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            step();
            if (gnt_d || gnt_r) begin
                seen = 1;
                check("E_draw_first", gnt_d, 1);
            end
        end
        check("E_grant_seen", seen, 1);

        // Random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            step();
            if (!(rq_d && !acc_d)) rq_d = ($urandom % 4) != 0;
            if (!(rq_r && !acc_r)) rq_r = ($urandom % 4) != 0;
            rst_n = ($urandom % 64) != 0;
        end
        rst_n = 1'b1; rq_d = 1'b0; rq_r = 1'b0;
        repeat (3) step();

        // MAX_BURST=1: alternate one beat each with a turnaround between
        @(posedge clk); #1;
        rst2_n = 1'b1; rq2 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            check("F_plot", plot2, (k >= 2) && (k % 2 == 0));
            check("F_gnt_draw", gnt2_d, (k % 4) == 1);
            check("F_gnt_ram", gnt2_r, (k % 4) == 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
